// File: rtl/mux41_rr_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter: states, requester indices,
// hold-counter width and the rotating-priority search.
package mux41_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int unsigned IDX_A = 0;
  localparam int unsigned IDX_B = 1;
  localparam int unsigned IDX_C = 2;
  localparam int unsigned IDX_D = 3;
  localparam int unsigned CNT_W = 8;

  // Returns {found, index} of the first set bit searching last+1 .. last+4 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/mux41_w.sv
// W-bit combinational 4:1 multiplexer selected by {S1,S0}.
module mux41_w
  import mux41_rr_arbiter_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] C,
  input  logic [W-1:0] D,
  input  logic         S1,
  input  logic         S0,
  output logic [W-1:0] Y
);

  always_comb begin
    Y = A;
    case ({S1, S0})
      2'(IDX_A): Y = A;
      2'(IDX_B): Y = B;
      2'(IDX_C): Y = C;
      2'(IDX_D): Y = D;
      default:   Y = A;
    endcase
  end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data path between requesters A..D, with a
// bounded hold time per owner and registered select/grant outputs.
module mux41_rr_arbiter
  import mux41_rr_arbiter_pkg::*;
#(
  parameter int unsigned W        = 1,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [3:0]   REQ,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] C,
  input  logic [W-1:0] D,
  output logic [3:0]   GNT,
  output logic         S1,
  output logic         S0,
  output logic         BUSY,
  output logic [W-1:0] Y
);

  state_e           r_state;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_gnt;
  logic [1:0]       r_sel;
  logic             r_busy;

  state_e           w_state_nxt;
  logic [1:0]       w_last_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_gnt_nxt;
  logic [1:0]       w_sel_nxt;
  logic             w_busy_nxt;
  logic [2:0]       w_pick;
  logic [2:0]       w_pick_oth;
  logic [W-1:0]     w_mux_y;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_last  <= 2'(IDX_D);
      r_cnt   <= '0;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'b00;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next grant; the "other" pick masks the current owner so a timed-out owner is skipped.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_pick      = rr_pick(REQ, r_last);
    w_pick_oth  = rr_pick(REQ & ~(4'b0001 << r_last), r_last);

    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt  = 4'b0000;
        w_busy_nxt = 1'b0;
        if (w_pick[2]) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = 4'b0001 << w_pick[1:0];
          w_sel_nxt   = w_pick[1:0];
          w_last_nxt  = w_pick[1:0];
          w_cnt_nxt   = CNT_W'(1);
          w_busy_nxt  = 1'b1;
        end
      end
      ST_GRANT: begin
        if (REQ[r_last] && (r_cnt < CNT_W'(HOLD_MAX))) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (w_pick_oth[2]) begin
          w_gnt_nxt  = 4'b0001 << w_pick_oth[1:0];
          w_sel_nxt  = w_pick_oth[1:0];
          w_last_nxt = w_pick_oth[1:0];
          w_cnt_nxt  = CNT_W'(1);
          w_busy_nxt = 1'b1;
        end else if (!REQ[r_last]) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 4'b0000;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 4'b0000;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  mux41_w #(.W(W)) u_mux (
    .A  (A),
    .B  (B),
    .C  (C),
    .D  (D),
    .S1 (r_sel[1]),
    .S0 (r_sel[0]),
    .Y  (w_mux_y)
  );

  assign GNT  = r_gnt;
  assign S1   = r_sel[1];
  assign S0   = r_sel[0];
  assign BUSY = r_busy;
  assign Y    = r_busy ? w_mux_y : '0;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed bench for mux41_rr_arbiter: reset, single requester, fairness, handover,
// priority wrap and hold timeout (second instance with HOLD_MAX=2).
module tb_mux41_rr_arbiter;

  logic       CLK;
  logic       RST_N;
  logic [3:0] REQ;
  logic [7:0] A, B, C, D;
  logic [3:0] GNT, GNT2;
  logic       S1, S0, S1_2, S0_2;
  logic       BUSY, BUSY2;
  logic [7:0] Y, Y2;

  int checks = 0;
  int errors = 0;

  mux41_rr_arbiter #(.W(8), .HOLD_MAX(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .A(A), .B(B), .C(C), .D(D),
    .GNT(GNT), .S1(S1), .S0(S0), .BUSY(BUSY), .Y(Y)
  );

  mux41_rr_arbiter #(.W(8), .HOLD_MAX(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .A(A), .B(B), .C(C), .D(D),
    .GNT(GNT2), .S1(S1_2), .S0(S0_2), .BUSY(BUSY2), .Y(Y2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse reset asynchronously mid-cycle, release on a falling edge.
  task automatic pulse_reset();
    @(negedge CLK);
    #2 RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; REQ = 4'b0000;
    A = 8'h11; B = 8'h22; C = 8'h5A; D = 8'h44;
    #1;
    checks++;
    if ({GNT, S1, S0, BUSY, Y} !== 15'h0) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b s=%b%b busy=%b y=%h, want all zero", GNT, S1, S0, BUSY, Y);
    end
    @(negedge CLK);
    RST_N = 1'b1; REQ = 4'b0001;
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0001 || BUSY !== 1'b1 || Y !== 8'h11) begin
      errors++;
      $display("FAIL first_grant_A: got gnt=%b busy=%b y=%h, want 0001 1 11", GNT, BUSY, Y);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (GNT !== 4'b0000 || BUSY !== 1'b0 || {S1, S0} !== 2'b00 || Y !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_mid_grant: got gnt=%b busy=%b s=%b%b y=%h, want 0000 0 00 00", GNT, BUSY, S1, S0, Y);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0001 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL grant_after_reset: got gnt=%b busy=%b, want 0001 1", GNT, BUSY);
    end
    REQ = 4'b0000;
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0000 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL release_to_idle: got gnt=%b busy=%b, want 0000 0", GNT, BUSY);
    end
  endtask

  task automatic test_single();
    REQ = 4'b0100;
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0100 || {S1, S0} !== 2'd2 || Y !== 8'h5A || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL single_C_grant: got gnt=%b s=%b%b y=%h busy=%b, want 0100 10 5a 1", GNT, S1, S0, Y, BUSY);
    end
    REQ = 4'b0000;
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0000 || BUSY !== 1'b0 || Y !== 8'h00 || {S1, S0} !== 2'd2) begin
      errors++;
      $display("FAIL single_C_release: got gnt=%b busy=%b y=%h s=%b%b, want 0000 0 00 10", GNT, BUSY, Y, S1, S0);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({S1, S0} !== 2'b00) begin
      errors++;
      $display("FAIL reset_clears_select: got s=%b%b, want 00", S1, S0);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_fairness();
    logic [3:0] exp_gnt;
    logic [1:0] exp_sel;
    logic [7:0] exp_y;
    logic [7:0] data [4];
    data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h5A; data[3] = 8'h44;
    REQ = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      @(negedge CLK);
      exp_sel = 2'((k / 4) % 4);
      exp_gnt = 4'b0001 << exp_sel;
      exp_y   = data[exp_sel];
      checks++;
      if (GNT !== exp_gnt || {S1, S0} !== exp_sel || BUSY !== 1'b1 || Y !== exp_y) begin
        errors++;
        $display("FAIL fairness_cycle%0d: got gnt=%b s=%b%b busy=%b y=%h, want %b %b 1 %h",
                 k, GNT, S1, S0, BUSY, Y, exp_gnt, exp_sel, exp_y);
      end
    end
    REQ = 4'b0000;
    @(negedge CLK);
  endtask

  task automatic test_handover();
    REQ = 4'b0001;
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0001) begin
      errors++;
      $display("FAIL handover_owner_A: got gnt=%b, want 0001", GNT);
    end
    REQ = 4'b1000;
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b1000 || BUSY !== 1'b1 || {S1, S0} !== 2'd3 || Y !== 8'h44) begin
      errors++;
      $display("FAIL handover_to_D: got gnt=%b busy=%b s=%b%b y=%h, want 1000 1 11 44", GNT, BUSY, S1, S0, Y);
    end
  endtask

  task automatic test_wrap();
    // D owns (from handover); release with A and C requesting.
    REQ = 4'b0101;
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0001 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL wrap_D_to_A: got gnt=%b busy=%b, want 0001 1", GNT, BUSY);
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge CLK);
      checks++;
      if (GNT !== 4'b0001) begin
        errors++;
        $display("FAIL wrap_A_hold%0d: got gnt=%b, want 0001", k, GNT);
      end
    end
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0100 || {S1, S0} !== 2'd2) begin
      errors++;
      $display("FAIL wrap_skip_B_to_C: got gnt=%b s=%b%b, want 0100 10", GNT, S1, S0);
    end
    REQ = 4'b0000;
    @(negedge CLK);
    checks++;
    if (GNT !== 4'b0000 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL wrap_idle: got gnt=%b busy=%b, want 0000 0", GNT, BUSY);
    end
  endtask

  task automatic test_timeout();
    pulse_reset();
    REQ = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      checks++;
      if (GNT2 !== 4'b0010 || BUSY2 !== 1'b1 || Y2 !== 8'h22) begin
        errors++;
        $display("FAIL timeout_B_hold%0d: got gnt=%b busy=%b y=%h, want 0010 1 22", k, GNT2, BUSY2, Y2);
      end
    end
    REQ = 4'b0011;
    @(negedge CLK);
    checks++;
    if (GNT2 !== 4'b0001 || {S1_2, S0_2} !== 2'd0 || Y2 !== 8'h11) begin
      errors++;
      $display("FAIL timeout_handover_A: got gnt=%b s=%b%b y=%h, want 0001 00 11", GNT2, S1_2, S0_2, Y2);
    end
    REQ = 4'b0000;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_handover();
    test_wrap();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
